// File: rtl/data_memory_responder.sv
// Data-memory responder: services one read or write at a time from a word-organised,
// byte-maskable memory and answers with a registered one-cycle Ack after WAIT_CYCLES wait states.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        ReadEnable,
    input  logic        WriteEnable,
    input  logic [3:0]  ByteEnable,
    output logic [31:0] ReadData,
    output logic        Ack,
    output logic        Err,
    output logic        Busy
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH_C  = 31'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          perr_q, perr_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req;
    logic          in_err;
    logic [AW-1:0] in_idx;
    logic          enter_resp;
    logic [AW-1:0] resp_idx;
    logic          resp_err;
    logic          resp_rd;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^Address[1:0];
    assign req    = ReadEnable | WriteEnable;
    assign in_err = ({1'b0, Address[31:2]} >= DEPTH_C) | (ReadEnable & WriteEnable);
    assign in_idx = Address[AW+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        perr_d     = perr_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        // With zero wait states the response is formed from the live inputs at the accept edge.
        resp_idx   = idx_q;
        resp_err   = perr_q;
        resp_rd    = rd_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d    = in_idx;
                    wdata_d  = WriteData;
                    be_d     = ByteEnable;
                    wr_d     = WriteEnable;
                    rd_d     = ReadEnable;
                    perr_d   = in_err;
                    busy_d   = 1'b1;
                    resp_idx = in_idx;
                    resp_err = in_err;
                    resp_rd  = ReadEnable;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
        endcase

        if (enter_resp) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
            ack_d   = 1'b1;
            err_d   = resp_err;
            rdata_d = (resp_rd && !resp_err) ? mem[resp_idx] : 32'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            perr_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            perr_q  <= perr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Commit on the edge leaving RESP; reset forces IDLE asynchronously, so a pending write is dropped.
    always_ff @(posedge CLK) begin
        if (state_q == S_RESP && wr_q && !perr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ReadData = rdata_q;
    assign Ack      = ack_q;
    assign Err      = err_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: one instance with two wait states, one with none,
// each with its own expected-response queue checked whenever Ack is seen.
module tb_data_memory_responder;

    localparam int W0 = 0;
    localparam int W2 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [31:0] addr0, wd0, rd0, addr2, wd2, rd2;
    logic        re0, we0, ack0, err0, busy0;
    logic        re2, we2, ack2, err2, busy2;
    logic [3:0]  be0, be2;

    // {check_data, data, err}
    logic [33:0] exp0_q[$];
    logic [33:0] exp2_q[$];
    int          cyc0_q[$];
    int          cyc2_q[$];

    logic [31:0] model [16];
    logic [31:0] dat0 [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0)) u_dut0 (
        .CLK(clk), .RST(rst_n), .Address(addr0), .WriteData(wd0),
        .ReadEnable(re0), .WriteEnable(we0), .ByteEnable(be0),
        .ReadData(rd0), .Ack(ack0), .Err(err0), .Busy(busy0)
    );

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W2)) u_dut2 (
        .CLK(clk), .RST(rst_n), .Address(addr2), .WriteData(wd2),
        .ReadEnable(re2), .WriteEnable(we2), .ByteEnable(be2),
        .ReadData(rd2), .Ack(ack2), .Err(err2), .Busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic ack_of(input int d);
        return (d == 0) ? ack0 : ack2;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : busy2;
    endfunction

    task automatic drive(input int d, input logic re, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (d == 0) begin
            re0 = re; we0 = we; addr0 = a; wd0 = wd; be0 = be;
        end else begin
            re2 = re; we2 = we; addr2 = a; wd2 = wd; be2 = be;
        end
    endtask

    task automatic push_exp(input int d, input logic chk, input logic [31:0] ed,
                            input logic ee, input int c);
        if (d == 0) begin
            exp0_q.push_back({chk, ed, ee});
            cyc0_q.push_back(c);
        end else begin
            exp2_q.push_back({chk, ed, ee});
            cyc2_q.push_back(c);
        end
    endtask

    task automatic drive_random(input int d);
        drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)));
    endtask

    // One request; scr scrambles the request inputs while the DUT is waiting.
    task automatic do_req(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic chk, input logic [31:0] ed, input logic ee, input logic scr);
        int n;
        @(negedge clk);
        drive(d, rd, wr, a, wd, be);
        push_exp(d, chk, ed, ee, cyc + 1 + ((d == 0) ? W0 : W2));
        @(negedge clk);
        check("busy_accept", 32'(busy_of(d)), 32'd1);
        if (scr) drive_random(d);
        else drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        n = 0;
        while (!ack_of(d) && n < 20) begin
            @(negedge clk);
            n++;
            if (scr && !ack_of(d)) drive_random(d);
        end
        check("ack_seen", 32'(ack_of(d)), 32'd1);
        drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check("ack_one_cycle", 32'(ack_of(d)), 32'd0);
        check("busy_drop", 32'(busy_of(d)), 32'd0);
    endtask

    task automatic wait_ack0();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack0 && n < 10);
        check("ack0_b2b", 32'(ack0), 32'd1);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        int c;
        if (rst_n && ack2) begin
            if (exp2_q.size() == 0) begin
                check("ack2_unexpected", 32'(ack2), 32'd0);
            end else begin
                e = exp2_q.pop_front();
                c = cyc2_q.pop_front();
                if (e[33]) check("rdata2", rd2, e[32:1]);
                check("err2", 32'(err2), 32'(e[0]));
                check("ack2_cycle", cyc, c);
            end
        end
    end

    always @(negedge clk) begin
        logic [33:0] e;
        int c;
        if (rst_n && ack0) begin
            if (exp0_q.size() == 0) begin
                check("ack0_unexpected", 32'(ack0), 32'd0);
            end else begin
                e = exp0_q.pop_front();
                c = cyc0_q.pop_front();
                if (e[33]) check("rdata0", rd0, e[32:1]);
                check("err0", 32'(err0), 32'(e[0]));
                check("ack0_cycle", cyc, c);
            end
        end
    end

    initial begin
        int k;
        logic [31:0] d;
        logic [3:0]  b;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack2), 32'd0);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_err", 32'(err2), 32'd0);
        check("rst_rdata", rd2, 32'd0);
        rst_n = 1'b1;

        // basic write/read
        do_req(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);

        // byte lanes, no-op write, ignored address LSBs
        do_req(2, 1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, 32'd0, 1'b0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADAAEF, 1'b0, 1'b0);
        do_req(2, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h13, 32'd0, 4'h0, 1'b1, 32'hDEADAAEF, 1'b0, 1'b0);

        // errors
        do_req(2, 1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h1000, 32'd0, 4'h0, 1'b1, 32'd0, 1'b1, 1'b0);
        do_req(2, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h0, 32'd0, 4'h0, 1'b1, 32'h11223344, 1'b0, 1'b0);
        do_req(2, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADAAEF, 1'b0, 1'b0);

        // reset during WAIT drops the pending write
        do_req(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(2, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("busy_in_wait", 32'(busy2), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(ack2), 32'd0);
        check("arst_busy", 32'(busy2), 32'd0);
        check("arst_err", 32'(err2), 32'd0);
        check("arst_rdata", rd2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_req(2, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);

        // inputs scrambled during WAIT
        do_req(2, 1'b0, 1'b1, 32'h40, 32'h5555AAAA, 4'hF, 1'b0, 32'd0, 1'b0, 1'b1);
        do_req(2, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b1, 32'h5555AAAA, 1'b0, 1'b1);

        // random byte-masked traffic against a 16-word model
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            do_req(2, 1'b0, 1'b1, 32'h200 + 32'(4 * i), model[i], 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                b = 4'($urandom_range(0, 15));
                for (int l = 0; l < 4; l++) if (b[l]) model[k][8*l +: 8] = d[8*l +: 8];
                do_req(2, 1'b0, 1'b1, 32'h200 + 32'(4 * k), d, b, 1'b0, 32'd0, 1'b0, 1'b0);
            end else begin
                do_req(2, 1'b1, 1'b0, 32'h200 + 32'(4 * k) + 32'($urandom_range(0, 3)), 32'd0,
                       4'h0, 1'b1, model[k], 1'b0, 1'b0);
            end
        end

        // zero wait states, back-to-back reads with ReadEnable held
        for (int i = 0; i < 3; i++) begin
            dat0[i] = $urandom;
            do_req(0, 1'b0, 1'b1, 32'(4 * i), dat0[i], 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        k = cyc + 1;
        re0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr0 = 32'(4 * i);
            push_exp(0, 1'b1, dat0[i], 1'b0, k + 2 * i);
            wait_ack0();
        end
        re0 = 1'b0;
        repeat (4) @(negedge clk);

        check("sb_drain0", 32'(exp0_q.size()), 32'd0);
        check("sb_drain2", 32'(exp2_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
